int_arbiter: RTL

Interrupt front end for the CPU. It takes N asynchronous interrupt lines and passes each through its own 3-flop synchronizer chain, then detects rising edges. Each edge is latched as a pending request. The block presents one request at a time to the CPU with fixed lowest-index-first priority, using a request/acknowledge handshake. It sits between external interrupt sources (buttons, UART, timers, GPU vsync) and the CPU interrupt input.

---
 rtl/int_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/int_arbiter.sv
// Interrupt front end: per-line 3-flop synchronizer, rising-edge capture into
// pending bits, and a lowest-index-first request/acknowledge presenter.
module int_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    int_in,
  input  logic [N-1:0]    int_mask,
  input  logic            int_ack,
  output logic            int_out,
  output logic [ID_W-1:0] int_id,
  output logic [N-1:0]    pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    s1_q, s1_d;
  logic [N-1:0]    s2_q, s2_d;
  logic [N-1:0]    s3_q, s3_d;
  logic [N-1:0]    prev_q, prev_d;
  logic [N-1:0]    pend_q, pend_d;
  logic            int_out_q, int_out_d;
  logic [ID_W-1:0] int_id_q, int_id_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    avail;
  logic            any_avail;
  logic [ID_W-1:0] low_id;

  always_comb begin
    s1_d   = int_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    prev_d = s3_q;
    rise   = s3_q & ~prev_q;
  end

  // Descending scan so the last hit, i.e. the lowest set index, wins.
  always_comb begin
    avail     = pend_q & ~int_mask;
    any_avail = |avail;
    low_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (avail[i]) begin
        low_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    int_out_d = int_out_q;
    int_id_d  = int_id_q;
    clr       = '0;
    case (state_q)
      S_IDLE: begin
        if (any_avail) begin
          int_id_d  = low_id;
          int_out_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          clr[int_id_q] = 1'b1;
          int_out_d     = 1'b0;
          state_d       = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        int_out_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    // A fresh edge on the line being acknowledged keeps it pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      int_out_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      int_out_q <= int_out_d;
      int_id_q  <= int_id_d;
    end
  end

  assign int_out = int_out_q;
  assign int_id  = int_id_q;
  assign pending = pend_q;

endmodule
